bcd_operand_entry: RTL and testbench

- Upstream stage of the single-digit BCD adder: turns board switch/key input into a registered, validated operand pair (A, B, carry-in) for the adder.
- User sets one BCD digit on switches and presses a key, once for A, once for B; the carry-in is sampled with B.
- Key input is synchronised and debounced. Digits above 9 are rejected.
- Results are offered to the adder with a valid/ready handshake.

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/key_debounce.sv | 80 ++++++++
 rtl/bcd_operand_entry.sv | 168 ++++++++++++++++
 tb/tb_bcd_operand_entry.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Definitions shared by the BCD operand-entry front end and the adder that
// consumes its operands.
//   BCD_W    width of one BCD digit
//   BCD_MAX  largest legal BCD digit
//   state_e  operand-entry FSM encoding (S_ILL only exists so that the
//            unused code point can be named; it always recovers to S_A)
//   is_bcd   unsigned range check of a single digit
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_PRES = 2'b10,
    S_ILL  = 2'b11
  } state_e;

  // Plain unsigned compare; 4'hA..4'hF are rejected, nothing wraps.
  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Conditions one raw active-low pushbutton: 2-flop synchroniser, debounce
// counter, and a one-cycle registered pulse on each debounced press.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synchronised samples required before
//                    the debounced level follows the key
// Ports
//   clk_i    system clock
//   rst_ni   synchronous active-low reset (key treated as released)
//   key_n_i  raw active-low key, asynchronous to clk_i
//   press_o  one-cycle pulse, registered, on a debounced 1->0 transition
//
// Timing: with key_n_i low from edge k, press_o is high during the cycle
// after edge k+DEBOUNCE_CYCLES+2.
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter flips the level on the sample that would take it to
  // DEBOUNCE_CYCLES, so the stored count never needs to hold that value.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          level_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Debounce next-state: count disagreement, adopt the new level once the
  // disagreement has lasted DEBOUNCE_CYCLES samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchroniser, debounce state and press edge detector.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= key_n_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      // Falling edge of the debounced level; a held key cannot repeat it.
      press_q     <= level_dly_q & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/bcd_operand_entry.sv
// ---------------------------------------------------------------------------
// bcd_operand_entry
// Front end of the single-digit BCD adder. The user sets a digit on the
// switches and presses a key once for A and once for B (carry-in sampled
// with B). Completed operand sets are offered downstream via valid/ready.
//
// Optional build macro: BCD_ENTRY_TIMEOUT_EN
//   defined   : an idle watchdog in S_B abandons entry after TIMEOUT_CYCLES
//               cycles (back to S_A, timeout=1, A retained)
//   undefined : no watchdog, timeout is constant 0, S_B waits indefinitely
//
// Parameters
//   DEBOUNCE_CYCLES  key debounce length (board build uses 500000)
//   TIMEOUT_CYCLES   S_B idle limit, only used with BCD_ENTRY_TIMEOUT_EN
// Ports
//   Clock      system clock, rising edge
//   Resetn     synchronous active-low reset
//   digit_in   candidate BCD digit (SW[3:0])
//   cin_in     carry-in request, sampled with B (SW[8])
//   load_n     raw active-low pushbutton (KEY[1])
//   op_ready   downstream accepts operands
//   A, B, c0   registered operands; hold after the handshake for display
//   op_valid   operands complete and offered (decoded from S_PRES)
//   entry_err  last press carried a non-BCD digit
//   state      current FSM state, for LEDR
//   timeout    entry abandoned by the watchdog
// ---------------------------------------------------------------------------
module bcd_operand_entry
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [BCD_W-1:0] digit_in,
  input  logic             cin_in,
  input  logic             load_n,
  input  logic             op_ready,
  output logic [BCD_W-1:0] A,
  output logic [BCD_W-1:0] B,
  output logic             c0,
  output logic             op_valid,
  output logic             entry_err,
  output logic [1:0]       state,
  output logic             timeout
);

  logic             press_s;
  logic             digit_ok_s;
  logic             accept_s;
  logic             tmo_expire_s;

  state_e           state_q;
  logic [BCD_W-1:0] a_q;
  logic [BCD_W-1:0] b_q;
  logic             c0_q;
  logic             err_q;
  logic             tmo_q;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_load_key (
    .clk_i   (Clock),
    .rst_ni  (Resetn),
    .key_n_i (load_n),
    .press_o (press_s)
  );

  assign digit_ok_s = is_bcd(digit_in);
  assign accept_s   = press_s & digit_ok_s;

`ifdef BCD_ENTRY_TIMEOUT_EN
  localparam int              TCW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0]  TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  logic [TCW-1:0] tmo_cnt_q;

  // Expiry is flagged on the cycle the count completes; an accepted press
  // on that same cycle takes priority in the FSM.
  assign tmo_expire_s = (state_q == S_B) && (tmo_cnt_q == TMO_LAST);

  // S_B idle counter; cleared whenever the FSM is about to leave S_B.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == S_B) && !accept_s && !tmo_expire_s) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  assign tmo_expire_s = 1'b0;

  // The idle limit has no effect when the watchdog is not built.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
  end
`endif

  // Operand-entry FSM with its registered outputs.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      c0_q    <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (accept_s) begin
            a_q     <= digit_in;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            state_q <= S_B;
          end else if (press_s) begin
            err_q <= 1'b1;
          end else begin
            state_q <= S_A;
          end
        end
        S_B: begin
          if (accept_s) begin
            b_q     <= digit_in;
            c0_q    <= cin_in;
            err_q   <= 1'b0;
            state_q <= S_PRES;
          end else begin
            // A rejected digit and watchdog expiry can coincide; both land.
            if (press_s) begin
              err_q <= 1'b1;
            end else begin
              err_q <= err_q;
            end
            if (tmo_expire_s) begin
              tmo_q   <= 1'b1;
              state_q <= S_A;
            end else begin
              state_q <= S_B;
            end
          end
        end
        S_PRES: begin
          // Presses are ignored here; only the handshake leaves S_PRES.
          if (op_ready) begin
            state_q <= S_A;
          end else begin
            state_q <= S_PRES;
          end
        end
        default: begin
          state_q <= S_A;
        end
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign c0        = c0_q;
  assign entry_err = err_q;
  assign timeout   = tmo_q;
  assign state     = state_q;
  assign op_valid  = (state_q == S_PRES);

endmodule

// File: tb/tb_bcd_operand_entry.sv
module tb_bcd_operand_entry;

  localparam int DB = 4;
  localparam int TO = 32;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       cin_in = 1'b0;
  logic       load_n = 1'b1;
  logic       op_ready = 1'b0;
  logic [3:0] A;
  logic [3:0] B;
  logic       c0;
  logic       op_valid;
  logic       entry_err;
  logic [1:0] state;
  logic       timeout;

  bcd_operand_entry #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Resetn(Resetn), .digit_in(digit_in), .cin_in(cin_in),
    .load_n(load_n), .op_ready(op_ready), .A(A), .B(B), .c0(c0),
    .op_valid(op_valid), .entry_err(entry_err), .state(state), .timeout(timeout)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: operand entry as a transaction-level phase machine.
  // phase 0 = waiting for A, 1 = waiting for B, 2 = operands offered.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
  } op_t;

  op_t        sb_q[$];
  op_t        mon_e;
  int         m_phase = 0;
  logic [3:0] m_a = 4'd0;
  logic [3:0] m_b = 4'd0;
  logic       m_c = 1'b0;
  logic       m_err = 1'b0;
  logic       m_tmo = 1'b0;

  task automatic model_reset();
    m_phase = 0; m_a = 4'd0; m_b = 4'd0; m_c = 1'b0; m_err = 1'b0; m_tmo = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_press(input logic [3:0] d, input logic c);
    if (m_phase == 0) begin
      if (int'(d) <= 9) begin m_a = d; m_err = 1'b0; m_tmo = 1'b0; m_phase = 1; end
      else m_err = 1'b1;
    end else if (m_phase == 1) begin
      if (int'(d) <= 9) begin
        m_b = d; m_c = c; m_err = 1'b0; m_phase = 2;
        sb_q.push_back('{a: m_a, b: d, c: c});
      end else m_err = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(m_phase));
    chk({tag, "_A"}, 32'(A), 32'(m_a));
    chk({tag, "_B"}, 32'(B), 32'(m_b));
    chk({tag, "_c0"}, 32'(c0), 32'(m_c));
    chk({tag, "_err"}, 32'(entry_err), 32'(m_err));
    chk({tag, "_valid"}, 32'(op_valid), (m_phase == 2) ? 32'd1 : 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'(m_tmo));
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected set.
  always @(negedge Clock) begin
    if (Resetn && op_valid && op_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got A=%0d B=%0d c0=%0d expected no offer", A, B, c0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_A", 32'(A), 32'(mon_e.a));
        chk("sb_B", 32'(B), 32'(mon_e.b));
        chk("sb_c0", 32'(c0), 32'(mon_e.c));
      end
    end
  end

  // Hold the key low for 'hold' sampled edges, then leave time to settle.
  task automatic do_press(input logic [3:0] d, input logic c, input int hold);
    @(posedge Clock); #1;
    digit_in = d; cin_in = c; load_n = 1'b0;
    repeat (hold) @(posedge Clock);
    #1 load_n = 1'b1;
    repeat (14) @(posedge Clock);
    #1;
    if (hold >= DB) model_press(d, c);
  endtask

  task automatic handshake();
    @(posedge Clock); #1 op_ready = 1'b1;
    @(posedge Clock); #1 op_ready = 1'b0;
    if (m_phase == 2) m_phase = 0;
  endtask

  // Key held low until the FSM leaves S_A; returns with the key released.
  task automatic enter_a_wait(input logic [3:0] d);
    bit seen = 1'b0;
    @(posedge Clock); #1 digit_in = d; load_n = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge Clock); #1;
      if (state == 2'd1) seen = 1'b1;
    end
    chk("enter_a_reached", 32'(seen), 32'd1);
    load_n = 1'b1;
    model_press(d, 1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] d;
    int r;
    // 1: reset then a full A/B/handshake transaction.
    Resetn = 1'b0;
    repeat (3) @(posedge Clock);
    #1 model_reset();
    check_state("reset");
    Resetn = 1'b1;
    do_press(4'd7, 1'b0, 6);
    check_state("t1_a");
    do_press(4'd5, 1'b1, 6);
    check_state("t1_b");
    handshake();
    check_state("t1_hs");

    // 2: exact capture latency, then no repeat while the key stays held.
    @(posedge Clock); #1 digit_in = 4'd3; load_n = 1'b0;
    repeat (7) @(posedge Clock);
    #1 chk("lat_early_state", 32'(state), 32'd0);
    @(posedge Clock); #1;
    model_press(4'd3, 1'b0);
    check_state("lat_edge");
    repeat (100) @(posedge Clock);
    #1 check_state("held");
    load_n = 1'b1;
    repeat (14) @(posedge Clock);
    #1;
    do_press(4'd8, 1'b0, 5);
    handshake();
    check_state("t2_hs");

    // 3: non-BCD digit rejected, then a legal digit clears the error.
    do_press(4'hC, 1'b0, 5);
    check_state("bad_digit");
    do_press(4'd2, 1'b0, 5);
    check_state("good_after_bad");

    // 4: short glitches, and presses ignored while operands are offered.
    do_press(4'd4, 1'b0, 3);
    check_state("glitch3");
    do_press(4'd6, 1'b1, 5);
    check_state("t4_b");
    do_press(4'd9, 1'b0, 6);
    check_state("pres_press");
    handshake();
    check_state("t4_hs");

    // Randomised mix of presses, glitches, bad digits and handshakes.
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        d = 4'($urandom_range(0, 15));
        do_press(d, 1'($urandom_range(0, 1)), int'($urandom_range(1, DB - 1)));
      end else if (r < 8) begin
        d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        do_press(d, 1'($urandom_range(0, 1)), int'($urandom_range(DB, DB + 4)));
      end else begin
        handshake();
        repeat (2) @(posedge Clock);
        #1;
      end
      check_state("rand");
    end

    // 5: reset while operands are offered.
    if (m_phase == 0) do_press(4'd1, 1'b0, 5);
    if (m_phase == 1) do_press(4'd2, 1'b1, 5);
    check_state("pre_rst");
    @(posedge Clock); #1 Resetn = 1'b0;
    @(posedge Clock); #1 model_reset();
    check_state("rst_pres");
    Resetn = 1'b1;
    // Reset just after the debounced level fell, before the press pulse.
    @(posedge Clock); #1 digit_in = 4'd6; load_n = 1'b0;
    repeat (6) @(posedge Clock);
    #1 Resetn = 1'b0; load_n = 1'b1;
    repeat (2) @(posedge Clock);
    #1 check_state("rst_debounce");
    Resetn = 1'b1;
    repeat (20) @(posedge Clock);
    #1 check_state("post_rst_quiet");

`ifdef BCD_ENTRY_TIMEOUT_EN
    // 6: watchdog expiry after TO idle cycles in S_B.
    enter_a_wait(4'd1);
    repeat (TO - 1) @(posedge Clock);
    #1 chk("tmo_before_state", 32'(state), 32'd1);
    @(posedge Clock); #1;
    m_phase = 0; m_tmo = 1'b1;
    check_state("tmo_expired");
    // Press landing on the expiry cycle wins.
    enter_a_wait(4'd1);
    check_state("tmo_reentry");
    repeat (24) @(posedge Clock);
    #1 digit_in = 4'd5; cin_in = 1'b1; load_n = 1'b0;
    repeat (8) @(posedge Clock);
    #1 model_press(4'd5, 1'b1);
    check_state("tmo_race");
    load_n = 1'b1;
    repeat (14) @(posedge Clock);
    handshake();
    check_state("tmo_hs");
`else
    // Without the watchdog, S_B waits indefinitely.
    enter_a_wait(4'd1);
    repeat (3 * TO) @(posedge Clock);
    #1 check_state("no_tmo");
    do_press(4'd4, 1'b0, 5);
    handshake();
    check_state("no_tmo_hs");
`endif

    repeat (3) @(posedge Clock);
    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
